led_pwm_dimmer: RTL



---
 rtl/led_pwm_dimmer_if.sv | 25 ++
 rtl/led_pwm_dimmer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/led_pwm_dimmer_if.sv
// Avalon-MM slave bus used by led_pwm_dimmer.
//   address    : 2-bit word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, combinational from address
// The master modport is driven by the CPU side (or a testbench).
// The slave modport is used by the dimmer.
interface led_pwm_dimmer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led_pwm_dimmer.sv
// LED PWM dimmer. Sits behind the 4-bit LED PIO. Adds per-channel 8-bit
// PWM brightness and a global blink gate to the PIO's LED request vector.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   avs      : Avalon-MM slave (4 words: CTRL, DUTY, PRESCALE, BLINK)
//   led_req  : LED request bits from the PIO, same clock domain
//   led_pwm  : registered LED drive
//
// Register map:
//   0 CTRL     [0] en, [1] blink_en
//   1 DUTY     [8i+7:8i] duty of channel i
//   2 PRESCALE [15:0] prescaler compare value
//   3 BLINK    [7:0] blink_div (R/W), [8] phase (RO), [23:16] pwm_cnt (RO)
module led_pwm_dimmer #(
  parameter logic [15:0] PRESCALE_DEFAULT = 16'd194
) (
  input  logic               clk,
  input  logic               reset_n,
  led_pwm_dimmer_if.slave    avs,
  input  logic [3:0]         led_req,
  output logic [3:0]         led_pwm
);

  logic        en;
  logic        blink_en;
  logic [31:0] duty;
  logic [15:0] prescale;
  logic [7:0]  blink_div;

  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [7:0]  blk_cnt;
  logic        phase;

  logic        we;
  logic        wr_ctrl;
  logic        wr_duty;
  logic        wr_prescale;
  logic        wr_blink;
  logic        tick;
  logic        wrap;
  logic [3:0]  on_vec;

  assign we          = avs.chipselect & ~avs.write_n;
  assign wr_ctrl     = we & (avs.address == 2'd0);
  assign wr_duty     = we & (avs.address == 2'd1);
  assign wr_prescale = we & (avs.address == 2'd2);
  assign wr_blink    = we & (avs.address == 2'd3);

  assign tick = en & (pre_cnt == prescale);
  assign wrap = tick & (pwm_cnt == 8'hFF);

  // Configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en        <= 1'b1;
      blink_en  <= 1'b0;
      duty      <= 32'hFFFF_FFFF;
      prescale  <= PRESCALE_DEFAULT;
      blink_div <= 8'd0;
    end else begin
      if (wr_ctrl) begin
        en       <= avs.writedata[0];
        blink_en <= avs.writedata[1];
      end
      if (wr_duty)     duty      <= avs.writedata;
      if (wr_prescale) prescale  <= avs.writedata[15:0];
      if (wr_blink)    blink_div <= avs.writedata[7:0];
    end
  end

  // Prescaler, PWM and blink counters. A PRESCALE write restarts the
  // prescaler but does not suppress a tick landing on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= 16'd0;
      pwm_cnt <= 8'd0;
      blk_cnt <= 8'd0;
      phase   <= 1'b0;
    end else if (!en) begin
      pre_cnt <= 16'd0;
      pwm_cnt <= 8'd0;
      blk_cnt <= 8'd0;
      phase   <= 1'b0;
    end else begin
      if (wr_prescale || tick) pre_cnt <= 16'd0;
      else                     pre_cnt <= pre_cnt + 16'd1;

      if (tick) pwm_cnt <= pwm_cnt + 8'd1;

      if (!blink_en) begin
        blk_cnt <= 8'd0;
        phase   <= 1'b0;
      end else if (wrap) begin
        if (blk_cnt == blink_div) begin
          blk_cnt <= 8'd0;
          phase   <= ~phase;
        end else begin
          blk_cnt <= blk_cnt + 8'd1;
        end
      end
    end
  end

  // Duty 0xFF is forced fully on; otherwise the channel is high while
  // pwm_cnt is below its duty, so duty 0 never lights.
  always_comb begin
    on_vec = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      on_vec[i] = en & led_req[i] & ~(blink_en & phase) &
                  ((duty[8*i +: 8] == 8'hFF) | (pwm_cnt < duty[8*i +: 8]));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) led_pwm <= 4'b0000;
    else          led_pwm <= on_vec;
  end

  always_comb begin
    avs.readdata = 32'd0;
    case (avs.address)
      2'd0: avs.readdata = {30'd0, blink_en, en};
      2'd1: avs.readdata = duty;
      2'd2: avs.readdata = {16'd0, prescale};
      2'd3: avs.readdata = {8'd0, pwm_cnt, 7'd0, phase, blink_div};
      default: avs.readdata = 32'd0;
    endcase
  end

endmodule
